mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the maximum number of outstanding reads (power of 2, at least 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 SHALL have IMEM request ports imem_req_val (in, 1), imem_req_rdy (out, 1) and imem_req_addr (in, CPU_ADDR_BITS).
REQ-005 SHALL have IMEM response ports imem_rec_val (out, 1), imem_rec_rdy (in, 1) and imem_rec_data (out, CPU_DATA_BITS).
REQ-006 SHALL have DMEM request ports dmem_req_val (in, 1), dmem_req_rdy (out, 1), dmem_req_addr (in, CPU_ADDR_BITS), dmem_req_wdata (in, CPU_DATA_BITS), dmem_req_we (in, 1), dmem_req_be (in, 4) and dmem_req_tag (in, TAG_WIDTH).
REQ-007 SHALL have DMEM response ports dmem_rec_val (out, 1), dmem_rec_rdy (in, 1), dmem_rec_data (out, CPU_DATA_BITS) and dmem_rec_tag (out, TAG_WIDTH).
REQ-008 SHALL have memory request ports mem_req_val (out, 1), mem_req_rdy (in, 1), mem_req_addr, mem_req_wdata, mem_req_we and mem_req_be (out), with widths as on the DMEM request.
REQ-009 SHALL have memory response ports mem_resp_val (in, 1), mem_resp_rdy (out, 1) and mem_resp_data (in, CPU_DATA_BITS); responses arrive in order and only for reads.
REQ-010 SHALL have port err (out, 1): sticky flag set when a response arrives with no outstanding read.

Function
REQ-011 SHALL transfer on any channel only in a cycle where val and rdy are both high.
REQ-012 SHALL forward the granted request to mem_req_* combinationally, with zero added latency.
REQ-013 SHALL treat an IMEM request as a read with be=4'hF, we=0 and wdata=0.
REQ-014 SHALL, when not locked, grant between IMEM and DMEM round-robin, favouring the requester that was not granted last.
REQ-015 SHALL, when a grant is forwarded with mem_req_rdy low, set a lock so that neither the grant nor the forwarded fields change until the handshake completes.
REQ-016 SHALL drive the rdy output of the ungranted requester low.
REQ-017 SHALL block read grants while the outstanding count equals DEPTH, even if a pop occurs in the same cycle.
REQ-018 SHALL still grant DMEM stores while the outstanding count equals DEPTH.
REQ-019 SHALL, on each read handshake, push {source, tag} into the tracking FIFO; source is 0 for IMEM and 1 for DMEM, and tag is 0 for IMEM.
REQ-020 SHALL NOT push a store into the tracking FIFO; stores produce no response.
REQ-021 SHALL, while the FIFO is non-empty, route mem_resp to the rec port of the FIFO head source combinationally, and drive mem_resp_rdy from that port's rec_rdy.
REQ-022 SHALL pop the FIFO head on each mem_resp handshake.
REQ-023 SHALL allow push and pop in the same cycle; the count is unchanged and the read and write pointers wrap modulo DEPTH.
REQ-024 SHALL, while the FIFO is empty, hold mem_resp_rdy high, keep both rec_val outputs low, discard any response and set err.
REQ-025 SHALL have a round-trip read latency equal to the memory latency; a response SHALL never overtake an earlier read.

Reset
REQ-026 SHALL, while rst_n is low, clear the lock, count, pointers and err, and set the last grant to DMEM so that IMEM wins first.
REQ-027 SHALL, during reset, drive mem_req_val, imem_rec_val, dmem_rec_val, imem_req_rdy and dmem_req_rdy low.
REQ-028 SHALL, on reset in the middle of a transaction, abandon all outstanding reads; responses arriving after reset for those reads are handled per REQ-024.

Configuration
REQ-029 SHALL use macro MEM_ARB_DMEM_PRIO_EN: when defined, DMEM has fixed priority over IMEM whenever unlocked.
REQ-030 SHALL use round-robin arbitration per REQ-014 when MEM_ARB_DMEM_PRIO_EN is undefined.
REQ-031 SHALL keep locking, FIFO and routing behaviour identical in both configurations.

Structure
REQ-032 SHALL take CPU_ADDR_BITS, CPU_DATA_BITS and TAG_WIDTH from uarch_pkg.
REQ-033 SHALL define a tracking-entry typedef mem_arb_entry_t {src, tag} in uarch_pkg.
REQ-034 SHALL implement the tracking FIFO as sub-module mem_arb_fifo, parameterised on DEPTH and the entry type.

Verification
REQ-035 SHALL cover: both requesters valid from reset with mem_req_rdy=1 -> IMEM granted in cycle 1, DMEM in cycle 2, alternating thereafter.
REQ-036 SHALL cover: DMEM store addr 0x04, data 0xDEADBEEF, with mem_req_rdy low for 3 cycles -> the forwarded fields are stable and imem_req_rdy stays low until the handshake, and no FIFO push occurs.
REQ-037 SHALL cover: IMEM read 0x10, then DMEM read 0x08 with tag 5, then two responses 0x13 and 0xFFFFAAAA -> imem_rec_data=0x13, then dmem_rec_data=0xFFFFAAAA with dmem_rec_tag=5.
REQ-038 SHALL cover: 4 reads outstanding (DEPTH=4) -> IMEM and DMEM reads stalled while a DMEM store is still granted; after one response, a read is granted in the next cycle.
REQ-039 SHALL cover: mem_resp_val=1 with the FIFO empty -> both rec_val outputs stay 0, err=1 and stays 1 until reset.
REQ-040 SHALL cover: rst_n asserted with 2 reads outstanding -> after release the count is 0, IMEM wins first, and a late response sets err.

Source files
------------

// File: rtl/uarch_pkg.sv
// Shared micro-architecture widths plus the types used by the memory arbiter
// (requester source, lock state and the read-tracking entry).
package uarch_pkg;

  localparam int CPU_ADDR_BITS = 32;
  localparam int CPU_DATA_BITS = 32;
  localparam int TAG_WIDTH     = 4;

  typedef enum logic {
    SRC_IMEM = 1'b0,
    SRC_DMEM = 1'b1
  } mem_arb_src_e;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } mem_arb_state_e;

  typedef struct packed {
    logic                 src;
    logic [TAG_WIDTH-1:0] tag;
  } mem_arb_entry_t;

  function automatic mem_arb_src_e other_src(input mem_arb_src_e s);
    return (s == SRC_IMEM) ? SRC_DMEM : SRC_IMEM;
  endfunction

endpackage

// File: rtl/mem_arb_fifo.sv
// In-order tracking FIFO for outstanding reads; head is presented combinationally.
// Push and pop may coincide; pointers wrap naturally because DEPTH is a power of two.
module mem_arb_fifo
  import uarch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = mem_arb_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   empty,
  output logic   full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t        slots [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == CW'(0));
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = slots[rptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= PW'(0);
      rptr  <= PW'(0);
      count <= CW'(0);
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: only slots between rptr and wptr are ever read as valid.
  always_ff @(posedge clk) begin
    if (do_push) slots[wptr] <= push_data;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IMEM and DMEM and routes in-order read responses back.
// Build option: define MEM_ARB_DMEM_PRIO_EN for fixed DMEM priority instead of round-robin.
module mem_arbiter
  import uarch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     imem_req_val,
  output logic                     imem_req_rdy,
  input  logic [CPU_ADDR_BITS-1:0] imem_req_addr,
  output logic                     imem_rec_val,
  input  logic                     imem_rec_rdy,
  output logic [CPU_DATA_BITS-1:0] imem_rec_data,
  input  logic                     dmem_req_val,
  output logic                     dmem_req_rdy,
  input  logic [CPU_ADDR_BITS-1:0] dmem_req_addr,
  input  logic [CPU_DATA_BITS-1:0] dmem_req_wdata,
  input  logic                     dmem_req_we,
  input  logic [3:0]               dmem_req_be,
  input  logic [TAG_WIDTH-1:0]     dmem_req_tag,
  output logic                     dmem_rec_val,
  input  logic                     dmem_rec_rdy,
  output logic [CPU_DATA_BITS-1:0] dmem_rec_data,
  output logic [TAG_WIDTH-1:0]     dmem_rec_tag,
  output logic                     mem_req_val,
  input  logic                     mem_req_rdy,
  output logic [CPU_ADDR_BITS-1:0] mem_req_addr,
  output logic [CPU_DATA_BITS-1:0] mem_req_wdata,
  output logic                     mem_req_we,
  output logic [3:0]               mem_req_be,
  input  logic                     mem_resp_val,
  output logic                     mem_resp_rdy,
  input  logic [CPU_DATA_BITS-1:0] mem_resp_data,
  output logic                     err
);

  mem_arb_state_e state;
  mem_arb_state_e next_state;
  mem_arb_src_e   sel;
  mem_arb_src_e   lock_src;
  mem_arb_src_e   last_grant;
  logic           sel_val;
  logic           imem_ok;
  logic           dmem_ok;
  logic           mem_fire;
  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_push;
  logic           fifo_pop;
  mem_arb_entry_t push_entry;
  mem_arb_entry_t head;

  // A full tracker only blocks reads; DMEM stores never need a response slot.
  assign imem_ok = imem_req_val && !fifo_full;
  assign dmem_ok = dmem_req_val && (dmem_req_we || !fifo_full);

  // Grant selection: a pending lock pins the grant, otherwise arbitrate.
  always_comb begin
    sel     = SRC_IMEM;
    sel_val = 1'b0;
    if (state == ARB_LOCKED) begin
      sel     = lock_src;
      sel_val = (lock_src == SRC_DMEM) ? dmem_req_val : imem_req_val;
    end else begin
`ifdef MEM_ARB_DMEM_PRIO_EN
      sel = dmem_ok ? SRC_DMEM : SRC_IMEM;
`else
      if (imem_ok && dmem_ok) begin
        sel = other_src(last_grant);
      end else if (dmem_ok) begin
        sel = SRC_DMEM;
      end else begin
        sel = SRC_IMEM;
      end
`endif
      sel_val = imem_ok || dmem_ok;
    end
  end

  // Lock next-state: stall on a forwarded but unaccepted request, release on handshake.
  always_comb begin
    next_state = state;
    case (state)
      ARB_OPEN: begin
        if (mem_req_val && !mem_req_rdy) next_state = ARB_LOCKED;
        else                             next_state = ARB_OPEN;
      end
      ARB_LOCKED: begin
        if (mem_fire) next_state = ARB_OPEN;
        else          next_state = ARB_LOCKED;
      end
      default: next_state = ARB_OPEN;
    endcase
  end

  // Lock state, locked source, round-robin history and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_OPEN;
      lock_src   <= SRC_IMEM;
      last_grant <= SRC_DMEM;
      err        <= 1'b0;
    end else begin
      state <= next_state;
      if (mem_req_val && !mem_req_rdy) lock_src <= sel;
      if (mem_fire) last_grant <= sel;
      if (mem_resp_val && fifo_empty) err <= 1'b1;
    end
  end

  assign mem_req_val   = rst_n && sel_val;
  assign mem_fire      = mem_req_val && mem_req_rdy;
  assign mem_req_addr  = (sel == SRC_DMEM) ? dmem_req_addr : imem_req_addr;
  assign mem_req_wdata = (sel == SRC_DMEM) ? dmem_req_wdata : {CPU_DATA_BITS{1'b0}};
  assign mem_req_we    = (sel == SRC_DMEM) ? dmem_req_we : 1'b0;
  assign mem_req_be    = (sel == SRC_DMEM) ? dmem_req_be : 4'hF;
  assign imem_req_rdy  = mem_req_val && (sel == SRC_IMEM) && mem_req_rdy;
  assign dmem_req_rdy  = mem_req_val && (sel == SRC_DMEM) && mem_req_rdy;

  // Tracking entry for the read being accepted this cycle.
  always_comb begin
    push_entry.src = (sel == SRC_DMEM);
    push_entry.tag = (sel == SRC_DMEM) ? dmem_req_tag : {TAG_WIDTH{1'b0}};
  end

  assign fifo_push = mem_fire && !mem_req_we;
  assign fifo_pop  = mem_resp_val && mem_resp_rdy && !fifo_empty;

  mem_arb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (mem_arb_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // With nothing outstanding, responses are swallowed so a stray one cannot hang memory.
  assign mem_resp_rdy  = fifo_empty ? 1'b1 : (head.src ? dmem_rec_rdy : imem_rec_rdy);
  assign imem_rec_val  = rst_n && !fifo_empty && !head.src && mem_resp_val;
  assign dmem_rec_val  = rst_n && !fifo_empty && head.src && mem_resp_val;
  assign imem_rec_data = mem_resp_data;
  assign dmem_rec_data = mem_resp_data;
  assign dmem_rec_tag  = head.tag;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model of the arbitration rules.
module tb_mem_arbiter;
  import uarch_pkg::*;

  localparam int DEPTH = 4;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     imem_req_val, imem_req_rdy;
  logic [CPU_ADDR_BITS-1:0] imem_req_addr;
  logic                     imem_rec_val, imem_rec_rdy;
  logic [CPU_DATA_BITS-1:0] imem_rec_data;
  logic                     dmem_req_val, dmem_req_rdy;
  logic [CPU_ADDR_BITS-1:0] dmem_req_addr;
  logic [CPU_DATA_BITS-1:0] dmem_req_wdata;
  logic                     dmem_req_we;
  logic [3:0]               dmem_req_be;
  logic [TAG_WIDTH-1:0]     dmem_req_tag;
  logic                     dmem_rec_val, dmem_rec_rdy;
  logic [CPU_DATA_BITS-1:0] dmem_rec_data;
  logic [TAG_WIDTH-1:0]     dmem_rec_tag;
  logic                     mem_req_val, mem_req_rdy;
  logic [CPU_ADDR_BITS-1:0] mem_req_addr;
  logic [CPU_DATA_BITS-1:0] mem_req_wdata;
  logic                     mem_req_we;
  logic [3:0]               mem_req_be;
  logic                     mem_resp_val, mem_resp_rdy;
  logic [CPU_DATA_BITS-1:0] mem_resp_data;
  logic                     err;

  mem_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_val(imem_req_val), .imem_req_rdy(imem_req_rdy), .imem_req_addr(imem_req_addr),
    .imem_rec_val(imem_rec_val), .imem_rec_rdy(imem_rec_rdy), .imem_rec_data(imem_rec_data),
    .dmem_req_val(dmem_req_val), .dmem_req_rdy(dmem_req_rdy), .dmem_req_addr(dmem_req_addr),
    .dmem_req_wdata(dmem_req_wdata), .dmem_req_we(dmem_req_we), .dmem_req_be(dmem_req_be),
    .dmem_req_tag(dmem_req_tag),
    .dmem_rec_val(dmem_rec_val), .dmem_rec_rdy(dmem_rec_rdy), .dmem_rec_data(dmem_rec_data),
    .dmem_rec_tag(dmem_rec_tag),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_we(mem_req_we), .mem_req_be(mem_req_be),
    .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_data(mem_resp_data),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                   src;
    logic [TAG_WIDTH-1:0] tag;
  } ref_ent_t;

  ref_ent_t    mq[$];
  logic [31:0] mem_q[$];
  bit          locked, lock_src, last_g, m_err;
  bit          e_g, e_gv, e_hv, e_rrdy;
  bit          hs_m, hs_i, hs_d, hs_r;
  int          n_cmp, n_bad;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Evaluate the reference model for the current inputs and compare all DUT outputs.
  task automatic check_comb();
    bit full, im_ok, dm_ok, hsrc;
    if (!rst_n) begin
      mq.delete();
      locked = 1'b0;
      last_g = 1'b1;
      m_err  = 1'b0;
    end
    #1;
    full  = (mq.size() == DEPTH);
    im_ok = imem_req_val && !full;
    dm_ok = dmem_req_val && (dmem_req_we || !full);
    if (locked) begin
      e_g  = lock_src;
      e_gv = lock_src ? dmem_req_val : imem_req_val;
    end else begin
`ifdef MEM_ARB_DMEM_PRIO_EN
      e_g = dm_ok;
`else
      e_g = (im_ok && dm_ok) ? !last_g : dm_ok;
`endif
      e_gv = im_ok || dm_ok;
    end
    e_gv = e_gv && rst_n;
    check_eq("mem_req_val", 32'(mem_req_val), 32'(e_gv));
    if (e_gv) begin
      check_eq("mem_req_addr", mem_req_addr, e_g ? dmem_req_addr : imem_req_addr);
      check_eq("mem_req_wdata", mem_req_wdata, e_g ? dmem_req_wdata : 32'h0);
      check_eq("mem_req_we", 32'(mem_req_we), e_g ? 32'(dmem_req_we) : 32'h0);
      check_eq("mem_req_be", 32'(mem_req_be), e_g ? 32'(dmem_req_be) : 32'hF);
    end
    check_eq("imem_req_rdy", 32'(imem_req_rdy), 32'(e_gv && !e_g && mem_req_rdy));
    check_eq("dmem_req_rdy", 32'(dmem_req_rdy), 32'(e_gv && e_g && mem_req_rdy));
    e_hv   = (mq.size() != 0);
    hsrc   = e_hv ? mq[0].src : 1'b0;
    e_rrdy = !e_hv ? 1'b1 : (hsrc ? dmem_rec_rdy : imem_rec_rdy);
    check_eq("mem_resp_rdy", 32'(mem_resp_rdy), 32'(e_rrdy));
    check_eq("imem_rec_val", 32'(imem_rec_val), 32'(rst_n && e_hv && !hsrc && mem_resp_val));
    check_eq("dmem_rec_val", 32'(dmem_rec_val), 32'(rst_n && e_hv && hsrc && mem_resp_val));
    if (rst_n && e_hv && mem_resp_val) begin
      if (hsrc) begin
        check_eq("dmem_rec_data", dmem_rec_data, mem_resp_data);
        check_eq("dmem_rec_tag", 32'(dmem_rec_tag), 32'(mq[0].tag));
      end else begin
        check_eq("imem_rec_data", imem_rec_data, mem_resp_data);
      end
    end
    check_eq("err", 32'(err), 32'(m_err));
  endtask

  // Advance the model across the clock edge and return at the next falling edge.
  task automatic tick();
    ref_ent_t ent;
    @(posedge clk);
    hs_m = e_gv && mem_req_rdy;
    hs_i = hs_m && !e_g;
    hs_d = hs_m && e_g;
    hs_r = rst_n && mem_resp_val && e_rrdy;
    if (rst_n) begin
      if (mem_resp_val && !e_hv) m_err = 1'b1;
      if (hs_r && e_hv) void'(mq.pop_front());
      if (hs_m) begin
        if (!(e_g && dmem_req_we)) begin
          ent.src = e_g;
          ent.tag = e_g ? dmem_req_tag : TAG_WIDTH'(0);
          mq.push_back(ent);
          mem_q.push_back((e_g ? dmem_req_addr : imem_req_addr) ^ 32'h1357_9BDF);
        end
        last_g = e_g;
        locked = 1'b0;
      end else if (e_gv) begin
        locked   = 1'b1;
        lock_src = e_g;
      end
    end
    @(negedge clk);
  endtask

  task automatic cycle();
    check_comb();
    tick();
  endtask

  task automatic idle();
    imem_req_val = 1'b0; imem_req_addr = 32'h0; imem_rec_rdy = 1'b1;
    dmem_req_val = 1'b0; dmem_req_addr = 32'h0; dmem_req_wdata = 32'h0;
    dmem_req_we = 1'b0; dmem_req_be = 4'hF; dmem_req_tag = TAG_WIDTH'(0); dmem_rec_rdy = 1'b1;
    mem_req_rdy = 1'b1; mem_resp_val = 1'b0; mem_resp_data = 32'h0;
  endtask

  task automatic respond(input logic [31:0] data);
    mem_resp_val = 1'b1; mem_resp_data = data;
    imem_rec_rdy = 1'b1; dmem_rec_rdy = 1'b1;
    cycle();
    mem_resp_val = 1'b0;
  endtask

  task automatic drain_directed();
    for (int i = 0; i < 16 && mq.size() != 0; i++) respond($urandom);
  endtask

  // Random requesters hold each request until accepted; memory answers in order.
  task automatic drive_random(input bit allow_new);
    if (!imem_req_val || hs_i) begin
      imem_req_val  = allow_new && ($urandom_range(0, 2) != 0);
      imem_req_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (!dmem_req_val || hs_d) begin
      dmem_req_val   = allow_new && ($urandom_range(0, 2) != 0);
      dmem_req_addr  = $urandom;
      dmem_req_wdata = $urandom;
      dmem_req_we    = ($urandom_range(0, 2) == 0);
      dmem_req_be    = 4'($urandom);
      dmem_req_tag   = TAG_WIDTH'($urandom);
    end
    mem_req_rdy  = ($urandom_range(0, 3) != 0);
    imem_rec_rdy = ($urandom_range(0, 3) != 0);
    dmem_rec_rdy = ($urandom_range(0, 3) != 0);
    if (mem_resp_val && hs_r) begin
      void'(mem_q.pop_front());
      mem_resp_val = 1'b0;
    end
    if (!mem_resp_val && mem_q.size() != 0 && $urandom_range(0, 2) != 0) begin
      mem_resp_val  = 1'b1;
      mem_resp_data = mem_q[0];
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    locked = 1'b0; lock_src = 1'b0; last_g = 1'b1; m_err = 1'b0;
    hs_m = 1'b0; hs_i = 1'b0; hs_d = 1'b0; hs_r = 1'b0;
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    imem_req_val = 1'b1; dmem_req_val = 1'b1;
    cycle(); cycle();
    rst_n = 1'b1;

    // Both requesters from reset: IMEM first, then strict alternation.
    imem_req_addr = 32'h100;
    dmem_req_we = 1'b1; dmem_req_addr = 32'h200; dmem_req_wdata = 32'h11;
    for (int i = 0; i < 4; i++) begin
      check_comb();
      check_eq("rr_imem_rdy", 32'(imem_req_rdy), 32'(i % 2 == 0));
      check_eq("rr_dmem_rdy", 32'(dmem_req_rdy), 32'(i % 2 == 1));
      tick();
    end
    idle();
    drain_directed();

    // Store stalled by memory: fields and grant held, no tracking entry.
    idle();
    mem_req_rdy = 1'b0;
    dmem_req_val = 1'b1; dmem_req_we = 1'b1; dmem_req_addr = 32'h4; dmem_req_wdata = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      check_comb();
      check_eq("st_addr", mem_req_addr, 32'h4);
      check_eq("st_wdata", mem_req_wdata, 32'hDEADBEEF);
      check_eq("st_imem_rdy", 32'(imem_req_rdy), 32'h0);
      tick();
      imem_req_val = 1'b1; imem_req_addr = 32'h20;
    end
    mem_req_rdy = 1'b1;
    check_comb();
    check_eq("st_hs", 32'(dmem_req_rdy), 32'h1);
    tick();
    dmem_req_val = 1'b0; imem_rec_rdy = 1'b0; dmem_rec_rdy = 1'b0;
    check_comb();
    check_eq("st_nopush", 32'(mem_resp_rdy), 32'h1);
    tick();
    idle();
    drain_directed();

    // Two reads then two in-order responses routed to the right requester.
    idle();
    imem_req_val = 1'b1; imem_req_addr = 32'h10;
    cycle();
    imem_req_val = 1'b0;
    dmem_req_val = 1'b1; dmem_req_addr = 32'h8; dmem_req_we = 1'b0; dmem_req_tag = TAG_WIDTH'(5);
    cycle();
    dmem_req_val = 1'b0;
    mem_resp_val = 1'b1; mem_resp_data = 32'h13;
    check_comb();
    check_eq("rt_imem_val", 32'(imem_rec_val), 32'h1);
    check_eq("rt_imem_data", imem_rec_data, 32'h13);
    check_eq("rt_dmem_val0", 32'(dmem_rec_val), 32'h0);
    tick();
    mem_resp_data = 32'hFFFFAAAA;
    check_comb();
    check_eq("rt_dmem_val", 32'(dmem_rec_val), 32'h1);
    check_eq("rt_dmem_data", dmem_rec_data, 32'hFFFFAAAA);
    check_eq("rt_dmem_tag", 32'(dmem_rec_tag), 32'h5);
    tick();
    idle();

    // Full tracker: reads stall, stores proceed, a pop re-opens reads a cycle later.
    imem_req_val = 1'b1; imem_req_addr = 32'h40;
    repeat (4) cycle();
    dmem_req_val = 1'b1; dmem_req_we = 1'b1; dmem_req_addr = 32'h44;
    check_comb();
    check_eq("full_store_val", 32'(mem_req_val), 32'h1);
    check_eq("full_store_we", 32'(mem_req_we), 32'h1);
    check_eq("full_imem_rdy", 32'(imem_req_rdy), 32'h0);
    tick();
    dmem_req_we = 1'b0;
    check_comb();
    check_eq("full_read_block", 32'(mem_req_val), 32'h0);
    tick();
    dmem_req_val = 1'b0;
    mem_resp_val = 1'b1; mem_resp_data = 32'hA1; imem_rec_rdy = 1'b1;
    check_comb();
    check_eq("full_pop_block", 32'(mem_req_val), 32'h0);
    tick();
    mem_resp_val = 1'b0;
    check_comb();
    check_eq("after_pop_grant", 32'(imem_req_rdy), 32'h1);
    tick();
    idle();
    drain_directed();

    // Stray response with nothing outstanding.
    idle();
    mem_resp_val = 1'b1; mem_resp_data = 32'h77;
    check_comb();
    check_eq("stray_imem_val", 32'(imem_rec_val), 32'h0);
    check_eq("stray_dmem_val", 32'(dmem_rec_val), 32'h0);
    check_eq("stray_rdy", 32'(mem_resp_rdy), 32'h1);
    tick();
    mem_resp_val = 1'b0;
    repeat (3) begin
      check_comb();
      check_eq("err_sticky", 32'(err), 32'h1);
      tick();
    end

    // Randomized traffic, then a bounded drain.
    idle();
    mem_q.delete();
    hs_i = 1'b0; hs_d = 1'b0; hs_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      drive_random(1'b1);
      cycle();
    end
    for (int i = 0; i < 400; i++) begin
      drive_random(1'b0);
      cycle();
      if (mq.size() == 0 && mem_q.size() == 0 && !imem_req_val && !dmem_req_val && !mem_resp_val) break;
    end
    idle();
    imem_rec_rdy = 1'b0; dmem_rec_rdy = 1'b0;
    check_comb();
    check_eq("drain_empty", 32'(mem_resp_rdy), 32'h1);
    tick();
    idle();

    // Reset with two reads outstanding; a late response afterwards is an error.
    imem_req_val = 1'b1; imem_req_addr = 32'h80;
    cycle(); cycle();
    dmem_req_val = 1'b1; dmem_req_we = 1'b1;
    rst_n = 1'b0;
    check_comb();
    check_eq("rst_req_val", 32'(mem_req_val), 32'h0);
    check_eq("rst_err", 32'(err), 32'h0);
    tick();
    cycle();
    rst_n = 1'b1;
    imem_req_val = 1'b0; dmem_req_val = 1'b0;
    imem_rec_rdy = 1'b0; dmem_rec_rdy = 1'b0;
    mem_resp_val = 1'b1; mem_resp_data = 32'h5;
    check_comb();
    check_eq("rst_cnt0", 32'(mem_resp_rdy), 32'h1);
    check_eq("late_imem_val", 32'(imem_rec_val), 32'h0);
    tick();
    mem_resp_val = 1'b0;
    imem_req_val = 1'b1; dmem_req_val = 1'b1;
    check_comb();
    check_eq("late_err", 32'(err), 32'h1);
    check_eq("rst_imem_first", 32'(imem_req_rdy), 32'h1);
    tick();
    idle();
    repeat (2) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
